// File: rtl/ana_capture_ctrl_pkg.sv
// Shared logic-analyzer definitions: capture depth, state encoding and trigger modes.
// Also used by the signal-memory variant and the register decode.
package ana_capture_ctrl_pkg;

    localparam int unsigned ANA_ADDR_WIDTH = 6;
    localparam int unsigned ANA_DEPTH      = 1 << ANA_ADDR_WIDTH;

    // The encoding is visible in the status register through state_dbg.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClear = 3'd1,
        StPre   = 3'd2,
        StArmed = 3'd3,
        StPost  = 3'd4,
        StDone  = 3'd5
    } ana_state_e;

    localparam logic [1:0] TRIG_LEVEL = 2'd0;  // masked match held for qual_len+1 cycles
    localparam logic [1:0] TRIG_EDGE  = 2'd1;  // masked match rising edge
    localparam logic [1:0] TRIG_IMM   = 2'd2;  // fire on the first armed cycle
    localparam logic [1:0] TRIG_FORCE = 2'd3;  // only force_trig fires

endpackage

// File: rtl/ana_capture_ctrl_if.sv
// Bus between the control-register bank, the capture sequencer and the signal memories.
//   master : register bank side (drives arm/abort/config/probe, reads status and write port)
//   slave  : capture sequencer (reads control, drives memory write port and status)
interface ana_capture_ctrl_if
    import ana_capture_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = ANA_ADDR_WIDTH,
    parameter int unsigned QUAL_WIDTH = 4
);
    logic                  arm;
    logic                  abort;
    logic                  force_trig;
    logic [1:0]            trig_mode;
    logic [DATA_WIDTH-1:0] trig_val;
    logic [DATA_WIDTH-1:0] trig_mask;
    logic [QUAL_WIDTH-1:0] qual_len;
    logic [ADDR_WIDTH-1:0] post_count;
    logic [DATA_WIDTH-1:0] probe;
    logic                  mem_clear;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] trig_addr;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic                  busy;
    logic                  triggered;
    logic                  done;
    logic [2:0]            state_dbg;

    modport master (
        output arm, abort, force_trig, trig_mode, trig_val, trig_mask, qual_len, post_count,
               probe,
        input  mem_clear, wr_en, wr_addr, trig_addr, start_addr, busy, triggered, done,
               state_dbg
    );

    modport slave (
        input  arm, abort, force_trig, trig_mode, trig_val, trig_mask, qual_len, post_count,
               probe,
        output mem_clear, wr_en, wr_addr, trig_addr, start_addr, busy, triggered, done,
               state_dbg
    );

endinterface

// File: rtl/ana_trig_match.sv
// Trigger qualification on one probe bus: masked compare, registered previous match,
// saturating consecutive-match counter and the combined fire decision.
//   clk, rst    : clock, async active-low reset
//   clear       : capture restart, zeroes history
//   enable      : sequencer is in ARMED; history only advances and fire only asserts here
//   force_trig  : unconditional fire while enabled
//   mode, val, mask, qual_len : latched trigger configuration
//   probe       : monitored bus
//   fire        : trigger this cycle (combinational)
module ana_trig_match
    import ana_capture_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned QUAL_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  force_trig,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] val,
    input  logic [DATA_WIDTH-1:0] mask,
    input  logic [QUAL_WIDTH-1:0] qual_len,
    input  logic [DATA_WIDTH-1:0] probe,
    output logic                  fire
);
    logic                  match;
    logic                  prev_q;
    logic                  enable_q;
    logic                  first;
    logic                  hit;
    logic [QUAL_WIDTH-1:0] run_q, run_d;

    assign match = ((probe ^ val) & mask) == '0;
    assign first = enable & ~enable_q;

    always_comb begin
        hit = 1'b0;
        case (mode)
            // run_q counts matches before this cycle, so this cycle makes qual_len+1
            TRIG_LEVEL: hit = match && (run_q >= qual_len);
            // prev_q is meaningless on entry; a match already present must not fire
            TRIG_EDGE:  hit = match && !prev_q && !first;
            TRIG_IMM:   hit = first;
            default:    hit = 1'b0;
        endcase
        fire = enable && (hit || force_trig);

        run_d = run_q;
        if (clear) begin
            run_d = '0;
        end else if (enable) begin
            if (!match) begin
                run_d = '0;
            end else if (run_q != '1) begin
                run_d = run_q + QUAL_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q   <= 1'b0;
            enable_q <= 1'b0;
            run_q    <= '0;
        end else begin
            enable_q <= enable;
            run_q    <= run_d;
            if (clear) begin
                prev_q <= 1'b0;
            end else if (enable) begin
                prev_q <= match;
            end
        end
    end

endmodule

// File: rtl/ana_capture_ctrl.sv
// Capture sequencer for the signal memories: clears the memories, pre-fills the ring,
// waits for a trigger, writes the post-trigger window and reports where the window starts.
//   clk, rst : clock, async active-low reset
//   bus      : slave side of ana_capture_ctrl_if (control/config in, write port/status out)
module ana_capture_ctrl
    import ana_capture_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = ANA_ADDR_WIDTH,
    parameter int unsigned QUAL_WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    ana_capture_ctrl_if.slave bus
);
    ana_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;

    // Configuration latched in CLEAR
    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] val_q;
    logic [DATA_WIDTH-1:0] mask_q;
    logic [QUAL_WIDTH-1:0] qual_q;
    logic [ADDR_WIDTH-1:0] post_q;

    logic                  writing;
    logic                  in_armed;
    logic                  fire;
    logic [ADDR_WIDTH-1:0] pre_last;

    assign writing  = (state_q == StPre) || (state_q == StArmed) || (state_q == StPost);
    assign in_armed = (state_q == StArmed);
    // Pre-fill length is D-1-post_count, i.e. ~post_count; last PRE count is one less.
    assign pre_last = ~post_q - ADDR_WIDTH'(1);

    ana_trig_match #(
        .DATA_WIDTH (DATA_WIDTH),
        .QUAL_WIDTH (QUAL_WIDTH)
    ) u_trig_match (
        .clk        (clk),
        .rst        (rst),
        .clear      (state_q == StClear),
        .enable     (in_armed),
        .force_trig (bus.force_trig),
        .mode       (mode_q),
        .val        (val_q),
        .mask       (mask_q),
        .qual_len   (qual_q),
        .probe      (bus.probe),
        .fire       (fire)
    );

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        cnt_d       = cnt_q;
        trig_addr_d = trig_addr_q;

        if (state_q == StClear) begin
            wr_addr_d = '0;
            cnt_d     = '0;
        end else if (writing) begin
            wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
            cnt_d     = cnt_q + ADDR_WIDTH'(1);
        end

        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (bus.arm) state_d = StClear;
                end
                StClear: begin
                    // post_count is being latched on this edge, so decide from the input
                    state_d = (bus.post_count == '1) ? StArmed : StPre;
                end
                StPre: begin
                    if (cnt_q == pre_last) state_d = StArmed;
                end
                StArmed: begin
                    if (fire) begin
                        trig_addr_d = wr_addr_q;
                        cnt_d       = '0;  // reused as the post-trigger sample counter
                        state_d     = (post_q == '0) ? StDone : StPost;
                    end
                end
                StPost: begin
                    if (cnt_q == post_q - ADDR_WIDTH'(1)) state_d = StDone;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            wr_addr_q   <= '0;
            cnt_q       <= '0;
            trig_addr_q <= '0;
            mode_q      <= '0;
            val_q       <= '0;
            mask_q      <= '0;
            qual_q      <= '0;
            post_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            cnt_q       <= cnt_d;
            trig_addr_q <= trig_addr_d;
            if (state_q == StClear) begin
                mode_q <= bus.trig_mode;
                val_q  <= bus.trig_val;
                mask_q <= bus.trig_mask;
                qual_q <= bus.qual_len;
                post_q <= bus.post_count;
            end
        end
    end

    // Everything except the address buses is decoded from the state flop alone.
    assign bus.mem_clear  = (state_q == StClear);
    assign bus.wr_en      = writing;
    assign bus.busy       = (state_q != StIdle) && (state_q != StDone);
    assign bus.done       = (state_q == StDone);
    assign bus.triggered  = (state_q == StPost) || (state_q == StDone);
    assign bus.wr_addr    = wr_addr_q;
    assign bus.trig_addr  = trig_addr_q;
    assign bus.start_addr = (state_q == StDone) ? wr_addr_q : '0;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_ana_capture_ctrl.sv
// Scoreboarded bench for ana_capture_ctrl: each capture pushes its expected window
// (trigger address, start address, write count, pre-fill length) and the monitor pops
// and compares it when done rises.
module tb_ana_capture_ctrl;
    import ana_capture_ctrl_pkg::*;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 6;
    localparam int unsigned QW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ana_capture_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .QUAL_WIDTH(QW)) bus ();

    ana_capture_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .QUAL_WIDTH (QW)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    typedef struct {
        int id;
        int trig_addr;
        int start_addr;
        int writes;
        int pre;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   mon_writes = 0;
    int   mon_pre = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: counts writes and PRE cycles since the last clear, scores on done rising.
    initial begin
        logic done_d;
        exp_t e;
        done_d = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_d = 1'b0;
            end else begin
                if (bus.mem_clear) begin
                    mon_writes = 0;
                    mon_pre    = 0;
                end else begin
                    if (bus.wr_en) mon_writes++;
                    if (bus.state_dbg == 3'd2) mon_pre++;
                end
                if (bus.done && !done_d) begin
                    if (sb_q.size() == 0) begin
                        check_val("sb_unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check_val($sformatf("cap%0d_trig_addr", e.id), bus.trig_addr, e.trig_addr);
                        check_val($sformatf("cap%0d_start_addr", e.id), bus.start_addr,
                                  e.start_addr);
                        check_val($sformatf("cap%0d_writes", e.id), mon_writes, e.writes);
                        check_val($sformatf("cap%0d_pre_cycles", e.id), mon_pre, e.pre);
                        check_val($sformatf("cap%0d_triggered", e.id), bus.triggered, 1);
                        check_val($sformatf("cap%0d_busy", e.id), bus.busy, 0);
                        check_val($sformatf("cap%0d_wr_en", e.id), bus.wr_en, 0);
                    end
                end
                done_d = bus.done;
            end
        end
    end

    task automatic push_exp(input int id, input int ta, input int sa, input int wr, input int pre);
        exp_t e;
        e.id = id; e.trig_addr = ta; e.start_addr = sa; e.writes = wr; e.pre = pre;
        sb_q.push_back(e);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (bus.state_dbg != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.state_dbg != s) check_val(tag, bus.state_dbg, s);
    endtask

    // Arms a capture and checks the clear pulse and the first write; then scrambles the
    // configuration inputs so only the latched copy can produce the right result.
    task automatic start_capture(input logic [1:0] mode, input logic [63:0] val,
                                 input logic [63:0] mask, input logic [3:0] qual,
                                 input logic [5:0] post);
        @(negedge clk);
        bus.trig_mode  = mode;
        bus.trig_val   = val;
        bus.trig_mask  = mask;
        bus.qual_len   = qual;
        bus.post_count = post;
        bus.arm        = 1'b1;
        @(negedge clk);
        bus.arm = 1'b0;
        check_val("clear_pulse", bus.mem_clear, 1);
        check_val("clear_state", bus.state_dbg, 3'd1);
        check_val("clear_no_write", bus.wr_en, 0);
        @(negedge clk);
        check_val("first_wr_en", bus.wr_en, 1);
        check_val("first_wr_addr", bus.wr_addr, 0);
        check_val("first_state", bus.state_dbg, (post == 6'd63) ? 3'd3 : 3'd2);
        bus.trig_mode  = TRIG_FORCE;
        bus.trig_val   = ~val;
        bus.trig_mask  = ~mask;
        bus.qual_len   = ~qual;
        bus.post_count = ~post;
    endtask

    // Drives one probe/force value per ARMED cycle; reports the cycle the trigger fired.
    task automatic drive_armed(input logic [63:0] mpat, input logic [63:0] fpat,
                               input logic [63:0] m_probe, input logic [63:0] n_probe,
                               output int fired_at);
        fired_at = -1;
        for (int i = 0; i < 64; i++) begin
            if (bus.state_dbg != 3'd3) begin
                fired_at = i - 1;
                break;
            end
            bus.probe      = mpat[i] ? m_probe : n_probe;
            bus.force_trig = fpat[i];
            @(negedge clk);
        end
        bus.force_trig = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fired;
        bus.arm = 0; bus.abort = 0; bus.force_trig = 0; bus.trig_mode = 0;
        bus.trig_val = 0; bus.trig_mask = 0; bus.qual_len = 0; bus.post_count = 0;
        bus.probe = 0;

        // Async reset before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_state", bus.state_dbg, 0);
        check_val("rst_wr_en", bus.wr_en, 0);
        check_val("rst_wr_addr", bus.wr_addr, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done", bus.done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_no_write", bus.wr_en, 0);

        // Level trigger, match first presented 10 cycles into ARMED
        bus.probe = 64'h0;
        start_capture(TRIG_LEVEL, 64'h5A, 64'hFF, 4'd0, 6'd16);
        push_exp(1, 57, 10, 74, 47);
        wait_state(3'd3, 100, "level_armed_timeout");
        drive_armed(64'h1 << 10, 64'h0, 64'h5A, 64'h0, fired);
        check_val("level_fire_cycle", fired, 10);
        wait_state(3'd5, 40, "level_done_timeout");
        repeat (2) @(negedge clk);
        check_val("done_held", bus.done, 1);
        check_val("done_wr_addr_held", bus.wr_addr, 10);

        // Qualifier: 3-cycle burst must not fire, 4-cycle burst fires on its 4th cycle;
        // arm pulsed during POST is ignored
        bus.probe = 64'h0;
        start_capture(TRIG_LEVEL, 64'hA5, 64'hFF, 4'd3, 6'd4);
        push_exp(2, 5, 10, 74, 59);
        wait_state(3'd3, 100, "qual_armed_timeout");
        drive_armed(64'h79C, 64'h0, 64'hA5, 64'h0, fired);
        check_val("qual_fire_cycle", fired, 10);
        bus.arm = 1'b1;
        @(negedge clk);
        bus.arm = 1'b0;
        check_val("post_arm_ignored", bus.state_dbg, 3'd4);
        wait_state(3'd5, 20, "qual_done_timeout");

        // Edge mode with a partial mask: match present on entry must not fire
        bus.probe = 64'hF3;
        start_capture(TRIG_EDGE, 64'h3, 64'h0F, 4'd0, 6'd8);
        push_exp(3, 62, 7, 71, 55);
        wait_state(3'd3, 100, "edge_armed_timeout");
        drive_armed(64'hFF9F, 64'h0, 64'hF3, 64'hF0, fired);
        check_val("edge_fire_cycle", fired, 7);
        wait_state(3'd5, 20, "edge_done_timeout");

        // post_count=0, forced in the first ARMED cycle: exactly D writes, DONE next cycle
        bus.probe = 64'h0;
        start_capture(TRIG_FORCE, 64'h0, 64'h0, 4'd0, 6'd0);
        push_exp(4, 63, 0, 64, 63);
        wait_state(3'd3, 100, "force_armed_timeout");
        drive_armed(64'h0, 64'h1, 64'h0, 64'h0, fired);
        check_val("force_fire_cycle", fired, 0);
        check_val("post0_done_next", bus.state_dbg, 3'd5);

        // post_count=63: no PRE phase, immediate trigger
        start_capture(TRIG_IMM, 64'h0, 64'h0, 4'd0, 6'd63);
        push_exp(5, 0, 0, 64, 0);
        drive_armed(64'h0, 64'h0, 64'h0, 64'h0, fired);
        check_val("imm_fire_cycle", fired, 0);
        wait_state(3'd5, 80, "imm_done_timeout");

        // abort wins over arm in ARMED
        start_capture(TRIG_FORCE, 64'h0, 64'h0, 4'd0, 6'd32);
        wait_state(3'd3, 100, "abort_armed_timeout");
        bus.abort = 1'b1;
        bus.arm   = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.arm   = 1'b0;
        check_val("abort_state", bus.state_dbg, 0);
        check_val("abort_wr_en", bus.wr_en, 0);
        check_val("abort_no_clear", bus.mem_clear, 0);
        check_val("abort_triggered", bus.triggered, 0);
        check_val("abort_done", bus.done, 0);
        check_val("abort_trig_held", bus.trig_addr, 0);
        @(negedge clk);
        check_val("abort_stays_idle", bus.state_dbg, 0);

        // Async reset in the middle of POST
        bus.probe = 64'h5A;
        start_capture(TRIG_LEVEL, 64'h5A, 64'hFF, 4'd0, 6'd40);
        wait_state(3'd4, 100, "rst_post_timeout");
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_state", bus.state_dbg, 0);
        check_val("midrst_wr_en", bus.wr_en, 0);
        check_val("midrst_wr_addr", bus.wr_addr, 0);
        check_val("midrst_trig_addr", bus.trig_addr, 0);
        check_val("midrst_triggered", bus.triggered, 0);
        check_val("midrst_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("postrst_idle", bus.state_dbg, 0);
            check_val("postrst_no_write", bus.wr_en, 0);
        end

        check_val("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
